onchip_mem_arbiter: RTL

Two-master round-robin arbiter that shares the single-port on-chip memory (32-bit words, 15-bit word address, 25600 words, byte enables, 1-cycle read latency) between two Avalon-MM-style requesters, e.g. the Nios II data master and a DMA engine. It sits between the masters and the memory macro. Each cycle it grants at most one access and routes read data back with `readdatavalid`. It also blocks out-of-range addresses and reports them through a sticky error flag.

---
 rtl/onchip_mem_arbiter_if.sv | 22 ++
 rtl/onchip_mem_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: Avalon-MM style requester bus, one instance per master.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master round-robin arbiter in front of a single-port on-chip memory.
module onchip_mem_arbiter #(
  parameter int          ADDR_W    = 15,
  parameter int          DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 25600
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oor,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_master,
  input  logic                err_clear
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);
  logic ready, last, rdv0, rdv1, rd_oor;
  logic req0, req1, g0, g1, acc, wr, oor;
  logic [ADDR_W-1:0] addr;
  // Ties go to the master that did not win the last accepted transfer.
  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    g0   = ready & req0 & (!req1 | last);
    g1   = ready & req1 & (!req0 | !last);
    acc  = g0 | g1;
    addr = g1 ? m1.address : m0.address;
    wr   = g1 ? m1.write : m0.write;
    oor  = {1'b0, addr} >= LIMIT;
  end
  assign m0.waitrequest   = !ready | (req0 & !g0);
  assign m1.waitrequest   = !ready | (req1 & !g1);
  assign mem_address      = addr;
  assign mem_byteenable   = g1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata    = g1 ? m1.writedata : m0.writedata;
  assign mem_chipselect   = acc & !oor;
  assign mem_write        = acc & !oor & wr;
  assign mem_clken        = ready;
  assign m0.readdata      = rd_oor ? '0 : mem_readdata;
  assign m1.readdata      = rd_oor ? '0 : mem_readdata;
  assign m0.readdatavalid = rdv0;
  assign m1.readdatavalid = rdv1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ready      <= 1'b0;
      last       <= 1'b1;
      rdv0       <= 1'b0;
      rdv1       <= 1'b0;
      rd_oor     <= 1'b0;
      err_oor    <= 1'b0;
      err_addr   <= '0;
      err_master <= 1'b0;
    end else begin
      ready  <= 1'b1;
      rdv0   <= g0 & !m0.write;
      rdv1   <= g1 & !m1.write;
      rd_oor <= acc & !wr & oor;
      if (acc) last <= g1;
      // A new error beats a simultaneous clear and is recaptured as the first one.
      if (acc & oor) begin
        err_oor <= 1'b1;
        if (!err_oor | err_clear) begin
          err_addr   <= addr;
          err_master <= g1;
        end
      end else if (err_clear) err_oor <= 1'b0;
    end
endmodule
